// File: rtl/iobuf_vec_pkg.sv
// Shared types and constants for the IobufVec bus master.
package iobuf_vec_pkg;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        WR,
        RD,
        RSP
    } state_t;

    // A released gap is needed only when the bus direction flips and gaps are enabled.
    function automatic logic needs_turn(input logic last_dir, input logic wr,
                                        input int unsigned turn_cycles);
        return (turn_cycles != 0) && (wr != last_dir);
    endfunction

endpackage

// File: rtl/iobuf_vec_master_if.sv
// Request/response stream plus pad-side pin bundle of the IobufVec bus master.
interface iobuf_vec_master_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req_vld;
    logic             req_rdy;
    logic             req_wr;
    logic [WIDTH-1:0] req_data;
    logic             rsp_vld;
    logic             rsp_rdy;
    logic [WIDTH-1:0] rsp_data;
    logic [WIDTH-1:0] pin_I;
    logic             pin_T;
    logic [WIDTH-1:0] pin_O;
    logic             pin_STB;

    modport master (
        input  req_vld, req_wr, req_data, rsp_rdy, pin_O,
        output req_rdy, rsp_vld, rsp_data, pin_I, pin_T, pin_STB
    );

    modport slave (
        output req_vld, req_wr, req_data, rsp_rdy, pin_O,
        input  req_rdy, rsp_vld, rsp_data, pin_I, pin_T, pin_STB
    );

endinterface

// File: rtl/iobuf_vec_master.sv
// Half-duplex strobed bus master for an IobufVec pad set: turns write/read
// requests into timed strobe cycles with turnaround gaps on direction changes.
module iobuf_vec_master
    import iobuf_vec_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic               CLK,
    input  logic               RST,
    iobuf_vec_master_if.master bus,
    output logic               busy
);

    // Counter is CNT_W bits and counts down to 1, so both timings must fit it.
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > CNT_MAX) begin : g_bad_hold
        $error("iobuf_vec_master: HOLD_CYCLES out of range 1..15");
    end
    if (TURN_CYCLES > CNT_MAX) begin : g_bad_turn
        $error("iobuf_vec_master: TURN_CYCLES out of range 0..15");
    end

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_last_dir;
    logic                 r_wr;
    logic [WIDTH-1:0]     r_data;
    logic                 r_req_rdy;
    logic                 r_rsp_vld;
    logic [WIDTH-1:0]     r_rsp_data;
    logic [WIDTH-1:0]     r_pin_I;
    logic                 r_pin_T;
    logic                 r_pin_STB;
    logic                 r_busy;
    logic                 w_accept;

    assign w_accept     = bus.req_vld && r_req_rdy;

    assign bus.req_rdy  = r_req_rdy;
    assign bus.rsp_vld  = r_rsp_vld;
    assign bus.rsp_data = r_rsp_data;
    assign bus.pin_I    = r_pin_I;
    assign bus.pin_T    = r_pin_T;
    assign bus.pin_STB  = r_pin_STB;
    assign busy         = r_busy;

    // Sequencer: every output is registered with the value of the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_last_dir <= DIR_READ;
            r_wr       <= 1'b0;
            r_data     <= '0;
            r_req_rdy  <= 1'b0;
            r_rsp_vld  <= 1'b0;
            r_rsp_data <= '0;
            r_pin_I    <= '0;
            r_pin_T    <= 1'b1;
            r_pin_STB  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_rdy <= 1'b1;
                    if (w_accept) begin
                        r_req_rdy <= 1'b0;
                        r_busy    <= 1'b1;
                        r_wr      <= bus.req_wr;
                        r_data    <= bus.req_data;
                        if (needs_turn(r_last_dir, bus.req_wr, TURN_CYCLES)) begin
                            r_state <= TURN;
                            r_cnt   <= CNT_W'(TURN_CYCLES);
                        end else begin
                            r_state   <= bus.req_wr ? WR : RD;
                            r_cnt     <= CNT_W'(HOLD_CYCLES);
                            r_pin_STB <= 1'b1;
                            if (bus.req_wr) begin
                                r_pin_T <= 1'b0;
                                r_pin_I <= bus.req_data;
                            end
                        end
                    end
                end

                TURN: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state   <= r_wr ? WR : RD;
                        r_cnt     <= CNT_W'(HOLD_CYCLES);
                        r_pin_STB <= 1'b1;
                        if (r_wr) begin
                            r_pin_T <= 1'b0;
                            r_pin_I <= r_data;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                WR: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state    <= IDLE;
                        r_last_dir <= DIR_WRITE;
                        r_pin_T    <= 1'b1;
                        r_pin_STB  <= 1'b0;
                        r_req_rdy  <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                RD: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state    <= RSP;
                        r_last_dir <= DIR_READ;
                        r_pin_STB  <= 1'b0;
                        r_rsp_data <= bus.pin_O;
                        r_rsp_vld  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                RSP: begin
                    if (bus.rsp_rdy) begin
                        r_state   <= IDLE;
                        r_rsp_vld <= 1'b0;
                        r_req_rdy <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
